// File: rtl/cardinal_noc_pkg.sv
// Shared constants and helpers for the cardinal ring NoC.
// Flits use MSB-0 numbering: flit bit k is carried on vector index
// DATA_WIDTH-1-k, so flit bit 0 (VC) is the vector MSB.
package cardinal_noc_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int HOP_LO     = 8;
    localparam int HOP_W      = 8;
    localparam int VC_BIT     = 0;
    localparam int DIR_BIT    = 1;

    // Descending-vector positions of the MSB-0 flit fields
    localparam int VC_POS  = DATA_WIDTH - 1 - VC_BIT;
    localparam int DIR_POS = DATA_WIDTH - 1 - DIR_BIT;
    localparam int HOP_POS = DATA_WIDTH - HOP_LO - HOP_W;

    // Port indices
    localparam int CW        = 0;
    localparam int CCW       = 1;
    localparam int PE        = 2;
    localparam int NUM_PORTS = 3;
    localparam int NUM_VCS   = 2;

    // Direction encodings carried in the dir bit
    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // Round-robin pointer: which requester wins a tie
    typedef enum logic {
        FAVOR_REQ0 = 1'b0,
        FAVOR_REQ1 = 1'b1
    } arb_prio_e;

    function automatic logic [HOP_W-1:0] flit_hop(input logic [DATA_WIDTH-1:0] f);
        return f[HOP_POS +: HOP_W];
    endfunction

    // One hop consumed: hop value shifts right with zero fill
    function automatic logic [DATA_WIDTH-1:0] shift_hop(input logic [DATA_WIDTH-1:0] f);
        logic [DATA_WIDTH-1:0] r;
        r = f;
        r[HOP_POS +: HOP_W] = f[HOP_POS +: HOP_W] >> 1;
        return r;
    endfunction

endpackage

// File: rtl/cardinal_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer moves to the other
// requester after each grant; with no grant it holds. Grants are only
// issued while en is high (target buffer has room).
module cardinal_rr_arb2
    import cardinal_noc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    arb_prio_e ptr_reg;

    // Grant the favoured requester on a tie, otherwise whoever asks
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                grant = (ptr_reg == FAVOR_REQ1) ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    // Pointer update: favour the loser of the last grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= FAVOR_REQ0;
        end else if (grant[0]) begin
            ptr_reg <= FAVOR_REQ1;
        end else if (grant[1]) begin
            ptr_reg <= FAVOR_REQ0;
        end
    end

endmodule

// File: rtl/cardinal_ring_router.sv
// One node of the bidirectional 4-node ring. Each port (cw, ccw, pe) has
// a one-flit input and output buffer per VC. Polarity P alternates every
// cycle: VC P talks to the links, VC ~P moves flits between buffers.
// Optional counters: define CARDINAL_ROUTER_STATS_EN to add stat_inj,
// stat_del and stat_drop.
module cardinal_ring_router
    import cardinal_noc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cwsi,
    output logic                  cwri,
    input  logic [DATA_WIDTH-1:0] cwdi,
    input  logic                  ccwsi,
    output logic                  ccwri,
    input  logic [DATA_WIDTH-1:0] ccwdi,
    output logic                  cwso,
    input  logic                  cwro,
    output logic [DATA_WIDTH-1:0] cwdo,
    output logic                  ccwso,
    input  logic                  ccwro,
    output logic [DATA_WIDTH-1:0] ccwdo,
    input  logic                  pesi,
    output logic                  pero,
    input  logic [DATA_WIDTH-1:0] pedi,
    output logic                  peso,
    input  logic                  peri,
    output logic [DATA_WIDTH-1:0] pedo,
    output logic                  polarity
`ifdef CARDINAL_ROUTER_STATS_EN
    ,
    output logic [31:0]           stat_inj,
    output logic [31:0]           stat_del,
    output logic [31:0]           stat_drop
`endif
);

    logic                  polarity_reg;
    logic                  p;
    logic                  q;

    logic                  in_full_reg   [NUM_PORTS][NUM_VCS];
    logic                  in_full_next  [NUM_PORTS][NUM_VCS];
    logic [DATA_WIDTH-1:0] in_data_reg   [NUM_PORTS][NUM_VCS];
    logic [DATA_WIDTH-1:0] in_data_next  [NUM_PORTS][NUM_VCS];
    logic                  out_full_reg  [NUM_PORTS][NUM_VCS];
    logic                  out_full_next [NUM_PORTS][NUM_VCS];
    logic [DATA_WIDTH-1:0] out_data_reg  [NUM_PORTS][NUM_VCS];
    logic [DATA_WIDTH-1:0] out_data_next [NUM_PORTS][NUM_VCS];

    logic [NUM_PORTS-1:0]  send_in;
    logic [NUM_PORTS-1:0]  ready_down;
    logic [NUM_PORTS-1:0]  ready_in;
    logic [NUM_PORTS-1:0]  capture;
    logic [NUM_PORTS-1:0]  send_out;
    logic [DATA_WIDTH-1:0] data_in [NUM_PORTS];

    logic [1:0]            through_req;
    logic [1:0]            deliver_req;
    logic [1:0]            inj_req;
    logic                  pe_full;
    logic                  pe_hop_zero;
    logic                  drop;
    logic [1:0]            route_req  [NUM_PORTS];
    logic [1:0]            arb_req    [NUM_PORTS*NUM_VCS];
    logic                  arb_en     [NUM_PORTS*NUM_VCS];
    logic [1:0]            arb_grant  [NUM_PORTS*NUM_VCS];
    logic [1:0]            move_grant [NUM_PORTS];

    assign p        = polarity_reg;
    assign q        = ~polarity_reg;
    assign polarity = polarity_reg;

    assign send_in     = {pesi, ccwsi, cwsi};
    assign ready_down  = {peri, ccwro, cwro};
    assign data_in[CW]  = cwdi;
    assign data_in[CCW] = ccwdi;
    assign data_in[PE]  = pedi;

    // External phase: link handshakes on VC P for every port
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ext
        assign ready_in[gi] = ~in_full_reg[gi][p];
        assign capture[gi]  = send_in[gi] & ready_in[gi] & (data_in[gi][VC_POS] == p);
        assign send_out[gi] = out_full_reg[gi][p] & ready_down[gi];
    end

    assign cwri  = ready_in[CW];
    assign ccwri = ready_in[CCW];
    assign pero  = ready_in[PE];
    assign cwso  = send_out[CW];
    assign ccwso = send_out[CCW];
    assign peso  = send_out[PE];
    assign cwdo  = out_data_reg[CW][p];
    assign ccwdo = out_data_reg[CCW][p];
    assign pedo  = out_data_reg[PE][p];

    // Internal phase: ring inputs deliver at hop 0, else continue same way
    for (genvar gi = 0; gi < 2; gi++) begin : g_ring_req
        assign through_req[gi] = in_full_reg[gi][q] & (flit_hop(in_data_reg[gi][q]) != '0);
        assign deliver_req[gi] = in_full_reg[gi][q] & (flit_hop(in_data_reg[gi][q]) == '0);
    end

    // PE input picks a ring direction; a hop-0 injection is discarded
    assign pe_full      = in_full_reg[PE][q];
    assign pe_hop_zero  = (flit_hop(in_data_reg[PE][q]) == '0);
    assign inj_req[CW]  = pe_full & ~pe_hop_zero & (in_data_reg[PE][q][DIR_POS] == DIR_CW);
    assign inj_req[CCW] = pe_full & ~pe_hop_zero & (in_data_reg[PE][q][DIR_POS] == DIR_CCW);
    assign drop         = pe_full & pe_hop_zero;

    // Requester 0 is through-traffic (ring outs) or cw (pe out)
    assign route_req[CW]  = {inj_req[CW], through_req[CW]};
    assign route_req[CCW] = {inj_req[CCW], through_req[CCW]};
    assign route_req[PE]  = {deliver_req[CCW], deliver_req[CW]};

    // One arbiter per output per VC; only the internal-phase VC sees requests
    for (genvar gi = 0; gi < NUM_PORTS * NUM_VCS; gi++) begin : g_arb
        localparam int   OUT_IDX = gi / NUM_VCS;
        localparam logic VC_IDX  = 1'(gi % NUM_VCS);

        assign arb_req[gi] = (q == VC_IDX) ? route_req[OUT_IDX] : 2'b00;
        assign arb_en[gi]  = ~out_full_reg[OUT_IDX][VC_IDX];

        cardinal_rr_arb2 u_arb (
            .clk   (clk),
            .reset (reset),
            .en    (arb_en[gi]),
            .req   (arb_req[gi]),
            .grant (arb_grant[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_grant
        assign move_grant[gi] = q ? arb_grant[gi*NUM_VCS + 1] : arb_grant[gi*NUM_VCS];
    end

    // Next buffer state: captures/sends touch VC P, moves touch VC ~P
    always_comb begin
        in_full_next  = in_full_reg;
        in_data_next  = in_data_reg;
        out_full_next = out_full_reg;
        out_data_next = out_data_reg;

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (capture[i]) begin
                in_full_next[i][p] = 1'b1;
                in_data_next[i][p] = data_in[i];
            end
            if (send_out[i]) begin
                out_full_next[i][p] = 1'b0;
            end
        end

        for (int o = 0; o < 2; o++) begin
            if (move_grant[o][0]) begin
                out_full_next[o][q] = 1'b1;
                out_data_next[o][q] = shift_hop(in_data_reg[o][q]);
                in_full_next[o][q]  = 1'b0;
            end
            if (move_grant[o][1]) begin
                out_full_next[o][q] = 1'b1;
                out_data_next[o][q] = shift_hop(in_data_reg[PE][q]);
                in_full_next[PE][q] = 1'b0;
            end
        end

        if (move_grant[PE][0]) begin
            out_full_next[PE][q] = 1'b1;
            out_data_next[PE][q] = in_data_reg[CW][q];
            in_full_next[CW][q]  = 1'b0;
        end
        if (move_grant[PE][1]) begin
            out_full_next[PE][q] = 1'b1;
            out_data_next[PE][q] = in_data_reg[CCW][q];
            in_full_next[CCW][q] = 1'b0;
        end

        if (drop) begin
            in_full_next[PE][q] = 1'b0;
        end
    end

    // Buffer and polarity registers; reset discards everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            polarity_reg <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    in_full_reg[i][v]  <= 1'b0;
                    in_data_reg[i][v]  <= '0;
                    out_full_reg[i][v] <= 1'b0;
                    out_data_reg[i][v] <= '0;
                end
            end
        end else begin
            polarity_reg <= ~polarity_reg;
            in_full_reg  <= in_full_next;
            in_data_reg  <= in_data_next;
            out_full_reg <= out_full_next;
            out_data_reg <= out_data_next;
        end
    end

`ifdef CARDINAL_ROUTER_STATS_EN
    logic [31:0] stat_inj_reg;
    logic [31:0] stat_del_reg;
    logic [31:0] stat_drop_reg;

    // Wrapping event counters for injections, deliveries and drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_inj_reg  <= '0;
            stat_del_reg  <= '0;
            stat_drop_reg <= '0;
        end else begin
            if (capture[PE])  stat_inj_reg  <= stat_inj_reg + 32'd1;
            if (send_out[PE]) stat_del_reg  <= stat_del_reg + 32'd1;
            if (drop)         stat_drop_reg <= stat_drop_reg + 32'd1;
        end
    end

    assign stat_inj  = stat_inj_reg;
    assign stat_del  = stat_del_reg;
    assign stat_drop = stat_drop_reg;
`endif

endmodule

// File: tb/tb_cardinal_ring_router.sv
// Bench for cardinal_ring_router. Expected output flits go into one queue
// per output port; a negedge monitor pops and compares on every send.
// Flit vectors are [63:0]: index 63 is flit bit 0 (VC), 62 is dir,
// [55:48] is the hop field.
module tb_cardinal_ring_router;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cwsi = 1'b0, ccwsi = 1'b0, pesi = 1'b0;
    logic [63:0] cwdi = '0, ccwdi = '0, pedi = '0;
    logic        cwro = 1'b1, ccwro = 1'b1, peri = 1'b1;
    logic        cwri, ccwri, pero;
    logic        cwso, ccwso, peso;
    logic [63:0] cwdo, ccwdo, pedo;
    logic        polarity;
`ifdef CARDINAL_ROUTER_STATS_EN
    logic [31:0] stat_inj, stat_del, stat_drop;
`endif

    int total = 0;
    int bad   = 0;
    logic model_p;
    logic [63:0] exp_cw[$];
    logic [63:0] exp_ccw[$];
    logic [63:0] exp_pe[$];

    cardinal_ring_router dut (
        .clk      (clk),
        .reset    (reset),
        .cwsi     (cwsi),
        .cwri     (cwri),
        .cwdi     (cwdi),
        .ccwsi    (ccwsi),
        .ccwri    (ccwri),
        .ccwdi    (ccwdi),
        .cwso     (cwso),
        .cwro     (cwro),
        .cwdo     (cwdo),
        .ccwso    (ccwso),
        .ccwro    (ccwro),
        .ccwdo    (ccwdo),
        .pesi     (pesi),
        .pero     (pero),
        .pedi     (pedi),
        .peso     (peso),
        .peri     (peri),
        .pedo     (pedo),
        .polarity (polarity)
`ifdef CARDINAL_ROUTER_STATS_EN
        ,
        .stat_inj (stat_inj),
        .stat_del (stat_del),
        .stat_drop(stat_drop)
`endif
    );

    always #5 clk = ~clk;

    // Reference phase: 0 out of reset, toggles every edge
    always @(posedge clk or posedge reset) begin
        if (reset) model_p <= 1'b0;
        else       model_p <= ~model_p;
    end

    function automatic logic [63:0] mk(input logic vc, input logic dir,
                                       input logic [7:0] hop, input logic [7:0] pay);
        return {vc, dir, 6'b101101, hop, 8'h6E, 32'h1357_9BDF, pay};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic to_phase(input logic ph);
        next_cycle();
        if (model_p != ph) next_cycle();
    endtask

    // Monitor: every send must match the head of that port's queue
    always @(negedge clk) begin
        if (!reset) begin
            if (cwso) begin
                if (exp_cw.size() == 0) check("cw_unexpected_send", cwdo, 64'hx);
                else check("cw_data", cwdo, exp_cw.pop_front());
            end
            if (ccwso) begin
                if (exp_ccw.size() == 0) check("ccw_unexpected_send", ccwdo, 64'hx);
                else check("ccw_data", ccwdo, exp_ccw.pop_front());
            end
            if (peso) begin
                if (exp_pe.size() == 0) check("pe_unexpected_send", pedo, 64'hx);
                else check("pe_data", pedo, exp_pe.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fa, fb, ft1, fi1, ft2;

        // 1: reset values and polarity sequence
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t1_polarity_%0d", i), {63'd0, polarity}, {63'd0, 1'(i % 2)});
            check($sformatf("t1_ready_%0d", i), {61'd0, cwri, ccwri, pero}, 64'd7);
            check($sformatf("t1_send_%0d", i), {61'd0, cwso, ccwso, peso}, 64'd0);
            check($sformatf("t1_pedo_%0d", i), pedo, 64'd0);
            next_cycle();
        end

        // 2: PE injection clockwise, hop 0x03 -> 0x01, sent two cycles later
        to_phase(1'b0);
        fa = mk(1'b0, 1'b0, 8'h03, 8'hA5);
        pesi = 1'b1; pedi = fa;
        exp_cw.push_back(mk(1'b0, 1'b0, 8'h01, 8'hA5));
        @(negedge clk); check("t2_pero", {63'd0, pero}, 64'd1);
        next_cycle(); pesi = 1'b0;
        @(negedge clk); check("t2_cwso_early", {63'd0, cwso}, 64'd0);
        next_cycle();
        @(negedge clk); check("t2_cwso", {63'd0, cwso}, 64'd1);

        // 3: cw arrival with hop 0 delivered unchanged to PE on VC1
        to_phase(1'b1);
        fa = mk(1'b1, 1'b0, 8'h00, 8'h3C);
        cwsi = 1'b1; cwdi = fa;
        exp_pe.push_back(fa);
        next_cycle(); cwsi = 1'b0;
        @(negedge clk); check("t3_peso_early", {63'd0, peso}, 64'd0);
        next_cycle();
        @(negedge clk); check("t3_peso", {63'd0, peso}, 64'd1);

        // 4: backpressure on cw output, then ordered drain
        to_phase(1'b0);
        cwro = 1'b0;
        fa = mk(1'b0, 1'b0, 8'h01, 8'h11);
        fb = mk(1'b0, 1'b0, 8'h01, 8'h22);
        exp_cw.push_back(mk(1'b0, 1'b0, 8'h00, 8'h11));
        exp_cw.push_back(mk(1'b0, 1'b0, 8'h00, 8'h22));
        cwsi = 1'b1; cwdi = fa;
        next_cycle(); cwsi = 1'b0;
        next_cycle();
        @(negedge clk); check("t4_cwso_blocked", {63'd0, cwso}, 64'd0);
        check("t4_cwri_open", {63'd0, cwri}, 64'd1);
        cwsi = 1'b1; cwdi = fb;
        next_cycle(); cwsi = 1'b0;
        next_cycle();
        @(negedge clk); check("t4_cwri_full", {63'd0, cwri}, 64'd0);
        check("t4_cwso_held", {63'd0, cwso}, 64'd0);
        next_cycle();
        next_cycle(); cwro = 1'b1;
        @(negedge clk); check("t4_cwso_release", {63'd0, cwso}, 64'd1);
        next_cycle();
        next_cycle();
        @(negedge clk); check("t4_cwso_second", {63'd0, cwso}, 64'd1);

        // 5: through vs injection contention on ccw VC1, pointer alternation
        to_phase(1'b1);
        ft1 = mk(1'b1, 1'b1, 8'h02, 8'hB1);
        fi1 = mk(1'b1, 1'b1, 8'h03, 8'hC1);
        ft2 = mk(1'b1, 1'b1, 8'h07, 8'hB2);
        exp_ccw.push_back(mk(1'b1, 1'b1, 8'h01, 8'hB1));
        exp_ccw.push_back(mk(1'b1, 1'b1, 8'h01, 8'hC1));
        exp_ccw.push_back(mk(1'b1, 1'b1, 8'h03, 8'hB2));
        ccwsi = 1'b1; ccwdi = ft1; pesi = 1'b1; pedi = fi1;
        next_cycle(); ccwsi = 1'b0; pesi = 1'b0;
        @(negedge clk); check("t5_c1", {63'd0, ccwso}, 64'd0);
        next_cycle(); ccwsi = 1'b1; ccwdi = ft2;
        @(negedge clk); check("t5_c2", {63'd0, ccwso}, 64'd1);
        next_cycle(); ccwsi = 1'b0;
        @(negedge clk); check("t5_c3", {63'd0, ccwso}, 64'd0);
        next_cycle();
        @(negedge clk); check("t5_c4", {63'd0, ccwso}, 64'd1);
        next_cycle();
        @(negedge clk); check("t5_c5", {63'd0, ccwso}, 64'd0);
        next_cycle();
        @(negedge clk); check("t5_c6", {63'd0, ccwso}, 64'd1);

        // 6: reset with buffers full; flits are discarded
        to_phase(1'b0);
        cwro = 1'b0;
        cwsi = 1'b1; cwdi = mk(1'b0, 1'b0, 8'h01, 8'h55);
        next_cycle(); cwsi = 1'b0;
        next_cycle(); cwsi = 1'b1; cwdi = mk(1'b0, 1'b0, 8'h01, 8'h66);
        next_cycle(); cwsi = 1'b0;
        next_cycle();
        check("t6_cwri_before", {63'd0, cwri}, 64'd0);
        reset = 1'b1; cwro = 1'b1;
        #1;
        check("t6_polarity", {63'd0, polarity}, 64'd0);
        check("t6_ready", {61'd0, cwri, ccwri, pero}, 64'd7);
        check("t6_send", {61'd0, cwso, ccwso, peso}, 64'd0);
        check("t6_cwdo", cwdo, 64'd0);
        check("t6_pedo", pedo, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 7: hop-0 injection is dropped and frees the PE input buffer
        pesi = 1'b1; pedi = mk(1'b0, 1'b0, 8'h00, 8'h77);
        next_cycle(); pesi = 1'b0;
        next_cycle();
        @(negedge clk); check("t7_pero_freed", {63'd0, pero}, 64'd1);
`ifdef CARDINAL_ROUTER_STATS_EN
        check("t7_stat_drop", {32'd0, stat_drop}, 64'd1);
        check("t7_stat_inj", {32'd0, stat_inj}, 64'd1);
`endif

        // 8: cw and ccw both delivering on VC0, cw wins first
        to_phase(1'b0);
        fa = mk(1'b0, 1'b0, 8'h00, 8'h81);
        fb = mk(1'b0, 1'b1, 8'h00, 8'h82);
        exp_pe.push_back(fa);
        exp_pe.push_back(fb);
        cwsi = 1'b1; cwdi = fa; ccwsi = 1'b1; ccwdi = fb;
        next_cycle(); cwsi = 1'b0; ccwsi = 1'b0;
        @(negedge clk); check("t8_c1", {63'd0, peso}, 64'd0);
        next_cycle();
        @(negedge clk); check("t8_c2", {63'd0, peso}, 64'd1);
        next_cycle();
        @(negedge clk); check("t8_c3", {63'd0, peso}, 64'd0);
        next_cycle();
        @(negedge clk); check("t8_c4", {63'd0, peso}, 64'd1);
        next_cycle();
`ifdef CARDINAL_ROUTER_STATS_EN
        @(negedge clk); check("t8_stat_del", {32'd0, stat_del}, 64'd2);
`endif

        // Drain: nothing outstanding, nothing unexpected
        repeat (6) next_cycle();
        check("drain_cw", 64'(exp_cw.size()), 64'd0);
        check("drain_ccw", 64'(exp_ccw.size()), 64'd0);
        check("drain_pe", 64'(exp_pe.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
